// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-8 demultiplexer.
// Output count and select width are fixed by the routing topology.
package demux_pkg;

    localparam int DEMUX_N_OUT = 8;
    localparam int DEMUX_SEL_W = 3;

    typedef logic [DEMUX_SEL_W-1:0] demux_sel_t;
    typedef logic [DEMUX_N_OUT-1:0] demux_onehot_t;

endpackage : demux_pkg

// File: rtl/decoder_3to8.sv
// Combinational 3-to-8 decoder with enable: bit 'sel' carries 'en', all others are 0.
module decoder_3to8
    import demux_pkg::*;
(
    input  logic          en,
    input  demux_sel_t    sel,
    output demux_onehot_t onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = en;
    end

endmodule : decoder_3to8

// File: rtl/demultiplexer_1to8.sv
// Registered 1-to-8 demultiplexer: routes den to dout_<sel>, all other outputs 0.
// Outputs come straight from flops so downstream consumers never see decode glitches.
module demultiplexer_1to8
    import demux_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       den,
    input  logic [2:0] sel,
    output logic       dout_0,
    output logic       dout_1,
    output logic       dout_2,
    output logic       dout_3,
    output logic       dout_4,
    output logic       dout_5,
    output logic       dout_6,
    output logic       dout_7
);

    demux_onehot_t onehot;
    demux_onehot_t dout_d;
    demux_onehot_t dout_q;

    decoder_3to8 u_decoder (
        .en     (den),
        .sel    (sel),
        .onehot (onehot)
    );

    always_comb begin
        dout_d = onehot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout_0 = dout_q[0];
    assign dout_1 = dout_q[1];
    assign dout_2 = dout_q[2];
    assign dout_3 = dout_q[3];
    assign dout_4 = dout_q[4];
    assign dout_5 = dout_q[5];
    assign dout_6 = dout_q[6];
    assign dout_7 = dout_q[7];

endmodule : demultiplexer_1to8

// File: tb/tb_demultiplexer_1to8.sv
// Self-checking bench for demultiplexer_1to8: vector table, hand-written timing cases
// and a randomized run against a one-cycle-delayed reference decode.
module tb_demultiplexer_1to8;

    logic       clk;
    logic       rst_n;
    logic       den;
    logic [2:0] sel;
    logic       dout_0, dout_1, dout_2, dout_3, dout_4, dout_5, dout_6, dout_7;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       den;
        logic [2:0] sel;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[16];

    demultiplexer_1to8 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .den    (den),
        .sel    (sel),
        .dout_0 (dout_0),
        .dout_1 (dout_1),
        .dout_2 (dout_2),
        .dout_3 (dout_3),
        .dout_4 (dout_4),
        .dout_5 (dout_5),
        .dout_6 (dout_6),
        .dout_7 (dout_7)
    );

    assign dout = {dout_7, dout_6, dout_5, dout_4, dout_3, dout_2, dout_1, dout_0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_onehot(input string name, input logic [7:0] act);
        checks++;
        if ($countones(act) > 1) begin
            errors++;
            $display("FAIL %s: got %b, expected at most one bit set at %0t", name, act, $time);
        end
    endtask

    // Reference: output k is high exactly when the sampled strobe was on and aimed at k.
    function automatic logic [7:0] ref_decode(input logic d, input int s);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[k] = d && (s == k);
        end
        return r;
    endfunction

    initial begin
        logic       prev_den;
        logic [2:0] prev_sel;

        for (int k = 0; k < 8; k++) begin
            vecs[k]     = '{den: 1'b1, sel: 3'(k), exp: 8'(1 << k)};
            vecs[8 + k] = '{den: 1'b0, sel: 3'(k), exp: 8'h00};
        end

        // Reset held with an active strobe pending
        rst_n = 1'b0;
        den   = 1'b1;
        sel   = 3'd5;
        #3;
        check("reset_initial", dout, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("reset_after_edge", dout, 8'h00);
            @(negedge clk);
            check("reset_between_edges", dout, 8'h00);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("first_after_reset", dout, 8'h20);

        // Walk and disable table
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            den = vecs[i].den;
            sel = vecs[i].sel;
            @(posedge clk);
            #1;
            check($sformatf("table_%0d", i), dout, vecs[i].exp);
            check_onehot($sformatf("table_onehot_%0d", i), dout);
        end

        // Mid-cycle select change must not reach the outputs before the edge
        @(negedge clk);
        den = 1'b1;
        sel = 3'd3;
        @(posedge clk);
        #1 check("latency_sel3", dout, 8'h08);
        #2 sel = 3'd6;
        #1 check("latency_hold_sel3", dout, 8'h08);
        @(posedge clk);
        #1 check("latency_sel6", dout, 8'h40);

        // Asynchronous reset between edges
        @(negedge clk);
        sel = 3'd7;
        @(posedge clk);
        #1 check("async_pre", dout, 8'h80);
        #2 rst_n = 1'b0;
        #1 check("async_immediate", dout, 8'h00);
        @(posedge clk);
        #1 check("async_held", dout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("async_release", dout, 8'h80);

        // Randomized run
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            den      = 1'($urandom_range(0, 1));
            sel      = 3'($urandom_range(0, 7));
            prev_den = den;
            prev_sel = sel;
            @(posedge clk);
            #1;
            check("random", dout, ref_decode(prev_den, int'(prev_sel)));
            check_onehot("random_onehot", dout);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_demultiplexer_1to8
